// File: rtl/uart_tx_pkg.sv
// Shared definitions for the UART transmitter slice: FSM state encodings,
// status bit positions, default timing and the per-state line level helper.
package uart_tx_pkg;

  // 50 MHz system clock / 115200 baud
  localparam int CLKS_PER_BIT_DEFAULT = 434;
  localparam int DEPTH_DEFAULT        = 4;
  localparam int DATA_BITS            = 8;
  localparam int US_W                 = 2;

  // Status bit positions inside us[1:0]
  localparam int US_BUSY = 0;
  localparam int US_FULL = 1;

  typedef enum logic [1:0] {
    UART_IDLE  = 2'd0,
    UART_START = 2'd1,
    UART_DATA  = 2'd2,
    UART_STOP  = 2'd3
  } uart_state_t;

  // Serial line level driven while the FSM sits in a given state.
  function automatic logic line_level(input uart_state_t state, input logic data_bit);
    logic level;
    case (state)
      UART_IDLE:  level = 1'b1;
      UART_START: level = 1'b0;
      UART_DATA:  level = data_bit;
      UART_STOP:  level = 1'b1;
      default:    level = 1'b1;
    endcase
    return level;
  endfunction

endpackage

// File: rtl/uart_tx_if.sv
// Register-write style byte port plus status/serial outputs of the transmitter.
// master = CPU/register-file side, slave = transmitter.
interface uart_tx_if;
  import uart_tx_pkg::*;

  logic                 we;
  logic [DATA_BITS-1:0] wd;
  logic [US_W-1:0]      us;
  logic                 txd;

  modport master (output we, output wd, input us, input txd);
  modport slave  (input we, input wd, output us, output txd);
endinterface

// File: rtl/uart_tx_fifo.sv
// Small byte FIFO in front of the serialiser. Head is visible combinationally
// on dout; full is a register so a write on a full edge is always dropped,
// even when a pop happens on the same edge.
module uart_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             empty,
  output logic             full
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [PTR_W-1:0] wr_ptr_r;
  logic [PTR_W-1:0] rd_ptr_r;
  logic [CNT_W-1:0] count_r;
  logic [CNT_W-1:0] count_next_s;
  logic             full_r;
  logic             push_ok_s;
  logic             pop_ok_s;

  assign empty     = (count_r == CNT_W'(0));
  assign full      = full_r;
  assign dout      = mem_r[rd_ptr_r];
  assign push_ok_s = push & ~full_r;
  assign pop_ok_s  = pop & ~empty;

  // Occupancy after this edge; simultaneous push and pop leave it unchanged.
  always_comb begin
    count_next_s = count_r;
    case ({push_ok_s, pop_ok_s})
      2'b10:   count_next_s = count_r + CNT_W'(1);
      2'b01:   count_next_s = count_r - CNT_W'(1);
      default: count_next_s = count_r;
    endcase
  end

  // Pointers, occupancy and registered full flag; pointers wrap modulo DEPTH.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_r <= PTR_W'(0);
      rd_ptr_r <= PTR_W'(0);
      count_r  <= CNT_W'(0);
      full_r   <= 1'b0;
    end else begin
      if (push_ok_s) wr_ptr_r <= wr_ptr_r + PTR_W'(1);
      if (pop_ok_s)  rd_ptr_r <= rd_ptr_r + PTR_W'(1);
      count_r <= count_next_s;
      full_r  <= (count_next_s == CNT_W'(DEPTH));
    end
  end

  // Storage array; contents need no reset because occupancy gates every read.
  always_ff @(posedge clk) begin
    if (push_ok_s) mem_r[wr_ptr_r] <= din;
  end

endmodule

// File: rtl/uart_tx.sv
// CPU-side 8N1 UART transmitter. Bytes written on we/wd are queued in
// uart_fifo and shifted out LSB first on txd. us[1] = FIFO full,
// us[0] = busy (FIFO non-empty or frame in progress). txd and busy are
// registered from the pre-edge FSM state, so txd falls two edges after a
// write into an idle, empty transmitter.
module uart_tx
  import uart_tx_pkg::*;
#(
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT,
  parameter int DEPTH        = DEPTH_DEFAULT
) (
  input  logic       clk,
  input  logic       rst,
  uart_tx_if.slave   bus
);

  localparam int BAUD_W = $clog2(CLKS_PER_BIT);
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [2:0]        BIT_LAST  = 3'(DATA_BITS - 1);

  uart_state_t          state_r;
  uart_state_t          state_next_s;
  logic [BAUD_W-1:0]    baud_r;
  logic [2:0]           bit_idx_r;
  logic [DATA_BITS-1:0] shift_r;
  logic                 txd_r;
  logic                 busy_r;
  logic                 pop_s;
  logic                 bit_done_s;
  logic [DATA_BITS-1:0] fifo_dout_s;
  logic                 fifo_empty_s;
  logic                 fifo_full_s;
  logic [US_W-1:0]      us_s;

  uart_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (DATA_BITS)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (bus.we),
    .din   (bus.wd),
    .pop   (pop_s),
    .dout  (fifo_dout_s),
    .empty (fifo_empty_s),
    .full  (fifo_full_s)
  );

  assign bit_done_s = (baud_r == BAUD_LAST);

  // Next-state and pop decision; STOP chains straight into START when data waits.
  always_comb begin
    state_next_s = state_r;
    pop_s        = 1'b0;
    case (state_r)
      UART_IDLE: begin
        if (!fifo_empty_s) begin
          pop_s        = 1'b1;
          state_next_s = UART_START;
        end else begin
          state_next_s = UART_IDLE;
        end
      end
      UART_START: begin
        if (bit_done_s) state_next_s = UART_DATA;
        else            state_next_s = UART_START;
      end
      UART_DATA: begin
        if (bit_done_s && (bit_idx_r == BIT_LAST)) state_next_s = UART_STOP;
        else                                       state_next_s = UART_DATA;
      end
      UART_STOP: begin
        if (bit_done_s && !fifo_empty_s) begin
          pop_s        = 1'b1;
          state_next_s = UART_START;
        end else if (bit_done_s) begin
          state_next_s = UART_IDLE;
        end else begin
          state_next_s = UART_STOP;
        end
      end
      default: begin
        state_next_s = UART_IDLE;
      end
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) state_r <= UART_IDLE;
    else     state_r <= state_next_s;
  end

  // Baud counter, bit index and shifter; everything restarts when a byte is popped.
  always_ff @(posedge clk) begin
    if (rst) begin
      baud_r    <= BAUD_W'(0);
      bit_idx_r <= 3'd0;
      shift_r   <= DATA_BITS'(0);
    end else if (pop_s) begin
      baud_r    <= BAUD_W'(0);
      bit_idx_r <= 3'd0;
      shift_r   <= fifo_dout_s;
    end else if (state_r == UART_IDLE) begin
      baud_r    <= BAUD_W'(0);
    end else if (bit_done_s) begin
      baud_r    <= BAUD_W'(0);
      if (state_r == UART_DATA) begin
        shift_r   <= {1'b0, shift_r[DATA_BITS-1:1]};
        bit_idx_r <= bit_idx_r + 3'd1;
      end
    end else begin
      baud_r    <= baud_r + BAUD_W'(1);
    end
  end

  // Registered line and busy flag, taken from the pre-edge FSM/FIFO state.
  always_ff @(posedge clk) begin
    if (rst) begin
      txd_r  <= 1'b1;
      busy_r <= 1'b0;
    end else begin
      txd_r  <= line_level(state_r, shift_r[0]);
      busy_r <= !fifo_empty_s || (state_r != UART_IDLE);
    end
  end

  // Pack the status word from the two registered flags.
  always_comb begin
    us_s          = 2'b00;
    us_s[US_BUSY] = busy_r;
    us_s[US_FULL] = fifo_full_s;
  end

  assign bus.us  = us_s;
  assign bus.txd = txd_r;

endmodule
